// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared widths, arbiter state encoding and owner encoding for the
//             instruction/data memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;

    typedef logic owner_t;
    localparam owner_t OWN_FETCH = 1'b0;
    localparam owner_t OWN_DATA  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module   : arb_prio_pick
//  Purpose  : Combinational grant selection between fetch and data requesters
//             with a data-burst starvation limit.
//  Revision : 1.0  initial release
// ============================================================================
module arb_prio_pick
    import cpu_mem_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int CNT_W          = 3
) (
    input  logic             i_fetch_req,
    input  logic             i_data_req,
    input  logic [CNT_W-1:0] i_burst_cnt,
    output logic             o_grant_any,
    output owner_t           o_grant_owner
);

    localparam logic [CNT_W-1:0] C_BURST_MAX = CNT_W'(MAX_DATA_BURST);

    logic w_starve;

    always_comb begin
        w_starve      = i_fetch_req && (i_burst_cnt == C_BURST_MAX);
        o_grant_any   = i_fetch_req || i_data_req;
        o_grant_owner = OWN_DATA;
        if (i_fetch_req && (w_starve || !i_data_req)) begin
            o_grant_owner = OWN_FETCH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Purpose  : Shares a single-ported memory between instruction fetch and the
//             MEM stage, one access outstanding, with per-requester stalls.
//  Revision : 1.0  initial release
// ============================================================================
module imem_dmem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W         = CPU_ADDR_W,
    parameter int DATA_W         = CPU_DATA_W,
    parameter int READ_LAT       = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_stall,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int C_LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int C_CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [C_LAT_W-1:0] C_LAT_LOAD  = C_LAT_W'(READ_LAT - 1);
    localparam logic [C_CNT_W-1:0] C_BURST_MAX = C_CNT_W'(MAX_DATA_BURST);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                is_wr_q, is_wr_d;
    logic                flushed_q, flushed_d;
    logic [C_LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [C_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                w_fetch_req_eff;
    logic                w_pick_any;
    owner_t              w_pick_owner;
    logic                w_resp;
    logic                w_grant;
    logic                w_grant_wr;
    logic [ADDR_W-1:0]   w_sel_addr;

    // A redirect in progress means the current PC is stale, so fetch is not arbitrated this cycle.
    assign w_fetch_req_eff = fetch_req && !fetch_flush;
    assign w_resp          = (state_q == WAIT) && (lat_cnt_q == '0);
    assign w_grant         = ((state_q == IDLE) || w_resp) && w_pick_any;
    assign w_grant_wr      = (w_pick_owner == OWN_DATA) && data_we;
    assign w_sel_addr      = (w_pick_owner == OWN_DATA) ? data_addr : fetch_addr;

    arb_prio_pick #(
        .MAX_DATA_BURST (MAX_DATA_BURST),
        .CNT_W          (C_CNT_W)
    ) u_pick (
        .i_fetch_req   (w_fetch_req_eff),
        .i_data_req    (data_req),
        .i_burst_cnt   (burst_cnt_q),
        .o_grant_any   (w_pick_any),
        .o_grant_owner (w_pick_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        is_wr_d     = is_wr_q;
        lat_cnt_d   = lat_cnt_q;
        burst_cnt_d = burst_cnt_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        flushed_d   = flushed_q;

        if (fetch_flush && (state_q != IDLE) && (owner_q == OWN_FETCH)) begin
            flushed_d = 1'b1;
        end

        case (state_q)
            ISSUE:   state_d = is_wr_q ? IDLE : WAIT;
            WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - C_LAT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_grant) begin
            state_d     = ISSUE;
            owner_d     = w_pick_owner;
            is_wr_d     = w_grant_wr;
            mem_rd_d    = !w_grant_wr;
            mem_wr_d    = w_grant_wr;
            mem_addr_d  = {w_sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = w_grant_wr ? data_wdata : mem_wdata_q;
            lat_cnt_d   = C_LAT_LOAD;
            flushed_d   = 1'b0;
        end

        if (!w_fetch_req_eff || (w_grant && (w_pick_owner == OWN_FETCH))) begin
            burst_cnt_d = '0;
        end else if (w_grant && (burst_cnt_q != C_BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            is_wr_q     <= 1'b0;
            flushed_q   <= 1'b0;
            lat_cnt_q   <= '0;
            burst_cnt_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            is_wr_q     <= is_wr_d;
            flushed_q   <= flushed_d;
            lat_cnt_q   <= lat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // A store completes as soon as its write strobe is out; reads complete in the response cycle.
    assign fetch_valid = w_resp && (owner_q == OWN_FETCH) && !flushed_q && !fetch_flush;
    assign data_valid  = (owner_q == OWN_DATA) &&
                         (w_resp || ((state_q == ISSUE) && is_wr_q));
    assign fetch_instr = mem_rdata;
    assign data_rdata  = mem_rdata;
    assign fetch_stall = fetch_req && !fetch_valid;
    assign data_stall  = data_req && !data_valid;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_dmem_arbiter
//  Purpose  : Scoreboard bench for imem_dmem_arbiter with a latency-accurate
//             memory model and directed fetch/load/store/flush/reset vectors.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_dmem_arbiter;

    localparam int LAT   = 3;
    localparam int BURST = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] val;
        logic        chk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, fetch_flush, fetch_valid, fetch_stall;
    logic [31:0] fetch_addr, fetch_instr;
    logic        data_req, data_we, data_valid, data_stall;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    exp_t        mem_q[$];
    exp_t        fv_q[$];
    exp_t        dv_q[$];
    logic [31:0] dcmd_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        dreq_open;
    logic [31:0] pa [LAT];
    logic        pv [LAT];

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .READ_LAT(LAT), .MAX_DATA_BURST(BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_stall(fetch_stall),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_valid(data_valid), .data_rdata(data_rdata), .data_stall(data_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Read data appears exactly LAT cycles after the mem_rd cycle, garbage otherwise.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= mem_rd;
            pa[0] <= mem_addr;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end
    assign mem_rdata = pv[LAT-1] ? mdata(pa[LAT-1]) : 32'hBAD0BAD0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got event with value %h, none expected (cycle %0d)", name, act, cyc);
    endtask

    task automatic exp_mem(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int c);
        mem_q.push_back('{wr: wr, addr: a, val: wd, chk: wr, cyc: c});
    endtask

    task automatic exp_fv(input logic [31:0] v, input int c);
        fv_q.push_back('{wr: 1'b0, addr: 32'h0, val: v, chk: 1'b1, cyc: c});
    endtask

    task automatic exp_dv(input logic [31:0] v, input logic ck, input int c);
        dv_q.push_back('{wr: 1'b0, addr: 32'h0, val: v, chk: ck, cyc: c});
    endtask

    always @(negedge clk) begin : monitor
        if (rst) begin
            dreq_open <= 1'b0;
        end else begin
            chk("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
            chk("valid_excl", 32'(fetch_valid & data_valid), 32'd0);
            if (dreq_open && !data_req && !data_valid)
                unexp("data_req_dropped_early", data_addr);
            dreq_open <= data_req && !data_valid;
            if (mem_rd || mem_wr) begin
                if (mem_q.size() == 0) begin
                    unexp("mem_access", mem_addr);
                end else begin
                    chk("mem_wr", 32'(mem_wr), 32'(mem_q[0].wr));
                    chk("mem_rd", 32'(mem_rd), 32'(!mem_q[0].wr));
                    chk("mem_addr", mem_addr, mem_q[0].addr);
                    if (mem_q[0].chk) chk("mem_wdata", mem_wdata, mem_q[0].val);
                    chk("mem_cycle", 32'(cyc), 32'(mem_q[0].cyc));
                    void'(mem_q.pop_front());
                end
            end
            if (fetch_valid) begin
                if (fv_q.size() == 0) begin
                    unexp("fetch_valid", fetch_instr);
                end else begin
                    chk("fetch_instr", fetch_instr, fv_q[0].val);
                    chk("fetch_cycle", 32'(cyc), 32'(fv_q[0].cyc));
                    void'(fv_q.pop_front());
                end
            end
            if (data_valid) begin
                if (dv_q.size() == 0) begin
                    unexp("data_valid", data_rdata);
                end else begin
                    if (dv_q[0].chk) chk("data_rdata", data_rdata, dv_q[0].val);
                    chk("data_cycle", 32'(cyc), 32'(dv_q[0].cyc));
                    void'(dv_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester model: drop a request in its valid cycle, or present the next queued load.
    task automatic serve(input string tag);
        int n = 0;
        while ((fetch_req || data_req) && n < 60) begin
            tick();
            n++;
            if (data_valid) begin
                if (dcmd_q.size() != 0) begin
                    data_we   = 1'b0;
                    data_addr = dcmd_q.pop_front();
                end else begin
                    data_req = 1'b0;
                    data_we  = 1'b0;
                end
            end
            if (fetch_valid) fetch_req = 1'b0;
        end
        if (fetch_req || data_req) begin
            unexp({tag, "_timeout"}, {30'b0, fetch_req, data_req});
            fetch_req = 1'b0;
            data_req  = 1'b0;
        end
        repeat (2) tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        logic [31:0] a;
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0; fetch_flush = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        tick();

        // Fetch only
        tick(); n0 = cyc;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        exp_mem(1'b0, 32'h10, 32'h0, n0 + 1);
        exp_fv(mdata(32'h10), n0 + 1 + LAT);
        #1 chk("t1_stall_n", 32'(fetch_stall), 32'd1);
        tick();
        chk("t1_stall_n1", 32'(fetch_stall), 32'd1);
        serve("t1");

        // Load and fetch together: data first
        tick(); n0 = cyc;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
        fetch_req = 1'b1; fetch_addr = 32'h20;
        exp_mem(1'b0, 32'h100, 32'h0, n0 + 1);
        exp_dv(mdata(32'h100), 1'b1, n0 + 1 + LAT);
        exp_mem(1'b0, 32'h20, 32'h0, n0 + 2 + LAT);
        exp_fv(mdata(32'h20), n0 + 2 + 2 * LAT);
        serve("t2");

        // Starvation limit: D,D,D,D,F,D,D
        tick(); n0 = cyc;
        fetch_req = 1'b1; fetch_addr = 32'h30;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h300;
        for (int k = 1; k < 6; k++) dcmd_q.push_back(32'h300 + 32'(4 * k));
        for (int k = 0; k < 7; k++) begin
            if (k == 4) begin
                exp_mem(1'b0, 32'h30, 32'h0, n0 + 1 + k * (LAT + 1));
                exp_fv(mdata(32'h30), n0 + 1 + LAT + k * (LAT + 1));
            end else begin
                a = 32'h300 + 32'(4 * ((k < 4) ? k : k - 1));
                exp_mem(1'b0, a, 32'h0, n0 + 1 + k * (LAT + 1));
                exp_dv(mdata(a), 1'b1, n0 + 1 + LAT + k * (LAT + 1));
            end
        end
        serve("t3");

        // Flush during WAIT, then fetch from the redirect target
        tick(); n0 = cyc;
        fetch_req = 1'b1; fetch_addr = 32'h50;
        exp_mem(1'b0, 32'h50, 32'h0, n0 + 1);
        tick();
        tick();
        fetch_flush = 1'b1; fetch_addr = 32'h40;
        tick();
        fetch_flush = 1'b0;
        exp_mem(1'b0, 32'h40, 32'h0, n0 + 2 + LAT);
        exp_fv(mdata(32'h40), n0 + 2 + 2 * LAT);
        serve("t4");

        // Store with unaligned address, followed by a load
        tick(); n0 = cyc;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h203; data_wdata = 32'hDEADBEEF;
        dcmd_q.push_back(32'h204);
        exp_mem(1'b1, 32'h200, 32'hDEADBEEF, n0 + 1);
        exp_dv(32'h0, 1'b0, n0 + 1);
        exp_mem(1'b0, 32'h204, 32'h0, n0 + 3);
        exp_dv(mdata(32'h204), 1'b1, n0 + 3 + LAT);
        serve("t5");

        // Reset in the middle of a read
        tick(); n0 = cyc;
        fetch_req = 1'b1; fetch_addr = 32'h60;
        exp_mem(1'b0, 32'h60, 32'h0, n0 + 1);
        tick();
        tick();
        rst = 1'b1; fetch_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_mem_rd", 32'(mem_rd), 32'd0);
        chk("t6_mem_wr", 32'(mem_wr), 32'd0);
        chk("t6_mem_addr", mem_addr, 32'd0);
        chk("t6_mem_wdata", mem_wdata, 32'd0);
        chk("t6_fetch_valid", 32'(fetch_valid), 32'd0);
        repeat (LAT + 2) tick();
        tick(); n0 = cyc;
        fetch_req = 1'b1; fetch_addr = 32'h70;
        exp_mem(1'b0, 32'h70, 32'h0, n0 + 1);
        exp_fv(mdata(32'h70), n0 + 1 + LAT);
        serve("t6");

        repeat (4) tick();
        chk("left_mem", 32'(mem_q.size()), 32'd0);
        chk("left_fetch", 32'(fv_q.size()), 32'd0);
        chk("left_data", 32'(dv_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
